// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Single-port data-memory target for the RV32i memory stage.
//                Accepts one word-aligned load/store per valid/ready
//                handshake, inserts WAIT_STATES idle cycles, then performs a
//                byte-enabled write or masked read on an internal word array
//                and presents a single response on a second valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DELAY       = 0,    // simulation-only output delay (ns)
    parameter int ADDR_BITS   = 10,   // word-address width
    parameter int WAIT_STATES = 2     // idle cycles, 0..15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int         c_DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] c_WS    = 4'(WAIT_STATES);

    // Reject parameter sets the counter or address split cannot represent.
    // DELAY has no effect on hardware; it only has to be non-negative.
    generate
        if ((WAIT_STATES < 0) || (WAIT_STATES > 15) ||
            (ADDR_BITS < 1) || (ADDR_BITS > 30) || (DELAY < 0)) begin : g_param_check
            $error("dmem_responder: illegal parameter setting");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    // Latched request, held from acceptance until the commit edge
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic [31:0] r_mem [0:c_DEPTH-1];

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_use_in;
    logic                 w_c_we;
    logic [31:0]          w_c_addr;
    logic [31:0]          w_c_wdata;
    logic [3:0]           w_c_be;
    logic                 w_c_err;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          w_mask;
    logic [31:0]          w_rd_word;

    // Ready is registered but must read 0 for the whole time reset is held,
    // including before the first reset edge has been seen.
    assign req_ready_o = r_req_ready & ~rst_i;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

    assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid_i;

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the request fields come straight from the inputs; otherwise from
    // the latched copy.
    assign w_commit = (w_accept && (c_WS == 4'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));
    assign w_use_in = (r_state == S_IDLE);

    assign w_c_we    = w_use_in ? req_we_i    : r_we;
    assign w_c_addr  = w_use_in ? req_addr_i  : r_addr;
    assign w_c_wdata = w_use_in ? req_wdata_i : r_wdata;
    assign w_c_be    = w_use_in ? req_be_i    : r_be;

    // Misaligned or beyond the top of the array
    assign w_c_err = (w_c_addr[1:0] != 2'b00) ||
                     ((w_c_addr >> (ADDR_BITS + 2)) != 32'd0);

    assign w_idx     = w_c_addr[ADDR_BITS+1:2];
    assign w_mask    = {{8{w_c_be[3]}}, {8{w_c_be[2]}}, {8{w_c_be[1]}}, {8{w_c_be[0]}}};
    assign w_rd_word = r_mem[w_idx];

    // Byte-lane store into the array; suppressed on error or during reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_commit && w_c_we && !w_c_err) begin
            for (int k = 0; k < 4; k++) begin
                if (w_c_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_c_wdata[8*k +: 8];
                end
            end
        end
    end

    // Request/response sequencing with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we_i;
                        r_addr      <= req_addr_i;
                        r_wdata     <= req_wdata_i;
                        r_be        <= req_be_i;
                        r_cnt       <= c_WS;
                        r_req_ready <= 1'b0;
                        r_state     <= (c_WS == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase

            // Response contents are fixed on the edge that enters RESP and
            // then held untouched until the response handshake.
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_c_err;
                r_rsp_rdata <= (w_c_err || w_c_we) ? 32'd0 : (w_rd_word & w_mask);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Instance 0 uses two
//                wait states, instance 1 uses none. Directed table, hand
//                sequences for backpressure, back-to-back and reset, then
//                random traffic against a transaction-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk;
    logic rst;

    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic [1:0]  rsp_ready;

    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [31:0] rsp_rdata0;
    wire  [31:0] rsp_rdata1;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DELAY(0), .ADDR_BITS(10), .WAIT_STATES(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_addr_i(req_addr[0]),
        .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rsp_rdata0), .rsp_err_o(rsp_err[0])
    );

    dmem_responder #(.DELAY(0), .ADDR_BITS(10), .WAIT_STATES(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_addr_i(req_addr[1]),
        .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rsp_rdata1), .rsp_err_o(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rdata(input int d);
        return (d == 0) ? rsp_rdata0 : rsp_rdata1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with rsp_ready held high; returns data, error flag
    // and the cycle (counted from the accept cycle) in which valid appeared.
    task automatic do_txn(input int d, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int cyc);
        int n;
        req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
        req_valid[d] = 1'b1;
        rsp_ready[d] = 1'b1;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        step();
        // Scramble request fields: only the acceptance edge may matter
        req_valid[d] = 1'b0;
        req_we[d] = 1'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
        cyc = 1;
        while (rsp_valid[d] !== 1'b1 && cyc < 50) begin step(); cyc++; end
        if (cyc >= 50) chk("rsp_timeout", 32'(cyc), 32'd0);
        rd = rdata(d);
        er = rsp_err[d];
        step();
        chk("post_hs_ready", {31'd0, req_ready[d]}, 32'd1);
        chk("post_hs_clear", {30'd0, rsp_valid[d], rsp_err[d]} | rdata(d), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [16];

    // Transaction-level model: 16 words per instance
    logic [31:0] mm [2][16];

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          n;
        int          lat [2];
        lat[0] = 3;
        lat[1] = 1;

        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};
        vt[2]  = '{1'b1, 32'h0000_0020, 32'h11223344, 4'b1111, 32'h0, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0};
        vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,        4'b1111, 32'h11BB33DD, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0020, 32'h0,        4'b0011, 32'h000033DD, 1'b0};
        vt[6]  = '{1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0};
        vt[7]  = '{1'b0, 32'h0000_0002, 32'h0,        4'b1111, 32'h0, 1'b1};
        vt[8]  = '{1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1};
        vt[9]  = '{1'b0, 32'h0000_0000, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0};
        vt[10] = '{1'b1, 32'h0000_0020, 32'h55555555, 4'b0000, 32'h0, 1'b0};
        vt[11] = '{1'b0, 32'h0000_0020, 32'h0,        4'b1100, 32'h11BB0000, 1'b0};
        vt[12] = '{1'b1, 32'h0000_0FFC, 32'h89ABCDEF, 4'b1111, 32'h0, 1'b0};
        vt[13] = '{1'b0, 32'h0000_0FFC, 32'h0,        4'b1111, 32'h89ABCDEF, 1'b0};
        vt[14] = '{1'b1, 32'h8000_0010, 32'h01010101, 4'b1111, 32'h0, 1'b1};
        vt[15] = '{1'b0, 32'h0000_0010, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0};

        rst = 1'b1;
        req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_be[d] = 4'd0;
        end

        // Reset behaviour
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready_low", {31'd0, req_ready[d]}, 32'd0);
            chk("rst_valid_low", {31'd0, rsp_valid[d]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'd0, req_ready[d]}, 32'd1);
            chk("reset_valid", {31'd0, rsp_valid[d]}, 32'd0);
            chk("reset_rdata", rdata(d), 32'd0);
            chk("reset_err",   {31'd0, rsp_err[d]}, 32'd0);
        end

        // Directed vectors on the two-wait-state instance
        for (int i = 0; i < 16; i++) begin
            do_txn(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, cyc);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd3);
        end

        // Backpressure: response held for 5 cycles, handshake in the 6th
        req_we[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
        req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin step(); n++; end
        step();
        req_addr[0] = 32'h20;   // still valid: must not be taken while busy
        cyc = 1;
        while (rsp_valid[0] !== 1'b1 && cyc < 50) begin step(); cyc++; end
        chk("bp_latency", 32'(cyc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid_held", {31'd0, rsp_valid[0]}, 32'd1);
            chk("bp_rdata_held", rdata(0), 32'hDEADBEEF);
            chk("bp_err_held",   {31'd0, rsp_err[0]}, 32'd0);
            chk("bp_ready_low",  {31'd0, req_ready[0]}, 32'd0);
        end
        rsp_ready[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        chk("bp_ready_after", {31'd0, req_ready[0]}, 32'd1);
        chk("bp_valid_after", {31'd0, rsp_valid[0]}, 32'd0);
        chk("bp_rdata_after", rdata(0), 32'd0);

        // Back-to-back loads on the zero-wait-state instance
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i) * 32'h0111_1111, 4'hF, rd, er, cyc);
        end
        rsp_ready[1] = 1'b1;
        req_we[1] = 1'b0; req_be[1] = 4'hF; req_addr[1] = 32'd0;
        req_valid[1] = 1'b1;
        chk("b2b_start_ready", {31'd0, req_ready[1]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("b2b%0d_valid", i), {31'd0, rsp_valid[1]}, 32'd1);
            chk($sformatf("b2b%0d_rdata", i), rdata(1), 32'h1000_0000 + 32'(i) * 32'h0111_1111);
            chk($sformatf("b2b%0d_busy", i), {31'd0, req_ready[1]}, 32'd0);
            req_addr[1] = 32'((i + 1) * 4);
            if (i == 3) req_valid[1] = 1'b0;
            step();
            chk($sformatf("b2b%0d_idle", i), {30'd0, req_ready[1], rsp_valid[1]}, 32'd2);
        end

        // Reset while a store sits in WAIT
        do_txn(0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, cyc);
        req_we[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'h12345678;
        req_be[0] = 4'hF; req_valid[0] = 1'b1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin step(); n++; end
        step();
        req_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_ready_forced", {31'd0, req_ready[0]}, 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("midrst_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("midrst_rdata", rdata(0), 32'd0);
        chk("midrst_err",   {31'd0, rsp_err[0]}, 32'd0);
        do_txn(0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, cyc);
        chk("midrst_readback", rd, 32'h0BADF00D);

        // Random traffic against the word model
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) begin
                mm[d][w] = $urandom;
                do_txn(d, 1'b1, 32'(w * 4), mm[d][w], 4'hF, rd, er, cyc);
                chk("rnd_init_err", {31'd0, er}, 32'd0);
            end
            for (int t = 0; t < 60; t++) begin
                logic        we;
                logic [3:0]  be;
                logic [31:0] a, wd, exp_rd;
                logic        exp_er;
                int          w, kind;
                we = 1'($urandom);
                be = 4'($urandom);
                wd = $urandom;
                w = $urandom_range(0, 15);
                kind = $urandom_range(0, 5);
                a = 32'(w * 4);
                if (kind == 0) a = a | 32'($urandom_range(1, 3));
                if (kind == 1) a = a | (32'd1 << $urandom_range(12, 31));
                exp_er = (kind <= 1);
                exp_rd = 32'd0;
                if (!exp_er) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) begin
                            if (we) mm[d][w][8*k +: 8] = wd[8*k +: 8];
                            else    exp_rd[8*k +: 8] = mm[d][w][8*k +: 8];
                        end
                    end
                end
                do_txn(d, we, a, wd, be, rd, er, cyc);
                chk($sformatf("rnd%0d_%0d_rdata", d, t), rd, exp_rd);
                chk($sformatf("rnd%0d_%0d_err", d, t), {31'd0, er}, {31'd0, exp_er});
                chk($sformatf("rnd%0d_%0d_lat", d, t), 32'(cyc), 32'(lat[d]));
            end
            // Final sweep confirms no stray writes
            for (int w = 0; w < 16; w++) begin
                do_txn(d, 1'b0, 32'(w * 4), 32'h0, 4'hF, rd, er, cyc);
                chk($sformatf("sweep%0d_%0d", d, w), rd, mm[d][w]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
